gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor.sv | 183 ++++++++++++++++++
 tb/tb_gshare_predictor.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
//   Global-history branch direction predictor. A table of saturating counters
//   is indexed either by the PC-derived index alone (bimodal) or by that index
//   XORed with a global history register (gshare). Lookups take one cycle.
//   The history is updated speculatively with each prediction and is repaired
//   from the history value carried with a branch when it resolves mispredicted.
//
// Ports
//   cpu_clk          in   1           clock, rising edge
//   cpu_rstn         in   1           synchronous active-low reset
//   predictor_ren    in   1           lookup request
//   predictor_raddr  in   ADDR_WIDTH  PC-derived lookup index
//   predict_valid    out  1           lookup result valid
//   predict_taken    out  1           predicted direction
//   predict_idx      out  ADDR_WIDTH  hashed index used for the lookup
//   predict_ghr      out  GHR_WIDTH   history used for the lookup
//   predictor_wen    in   1           resolve/update request
//   predictor_waddr  in   ADDR_WIDTH  hashed index carried back from predict_idx
//   branch_taken_ex  in   1           resolved direction
//   mispredict_ex    in   1           resolved mispredict (qualified by wen)
//   ghr_restore      in   GHR_WIDTH   predict_ghr carried with the branch
//   mispredict_cnt   out  16          saturating mispredict count
// -----------------------------------------------------------------------------
module gshare_predictor #(
  parameter int ENTRY_NUM  = 256,
  parameter int ADDR_WIDTH = $clog2(ENTRY_NUM),
  parameter int CNT_WIDTH  = 2,
  parameter int CNT_INIT   = 2**(CNT_WIDTH-1)-1,
  parameter int GHR_WIDTH  = 8,
  parameter int HASH_MODE  = 1
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  predictor_ren,
  input  logic [ADDR_WIDTH-1:0] predictor_raddr,
  output logic                  predict_valid,
  output logic                  predict_taken,
  output logic [ADDR_WIDTH-1:0] predict_idx,
  output logic [GHR_WIDTH-1:0]  predict_ghr,
  input  logic                  predictor_wen,
  input  logic [ADDR_WIDTH-1:0] predictor_waddr,
  input  logic                  branch_taken_ex,
  input  logic                  mispredict_ex,
  input  logic [GHR_WIDTH-1:0]  ghr_restore,
  output logic [15:0]           mispredict_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_MIN = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_RST = CNT_WIDTH'(CNT_INIT);
  localparam logic [15:0]          MCNT_MAX = 16'hFFFF;

  // Shift one outcome into a history value; the cast keeps this valid for a
  // one-bit history, where the result is just the new outcome.
  function automatic logic [GHR_WIDTH-1:0] ghr_shift(
    input logic [GHR_WIDTH-1:0] hist,
    input logic                 bit_in
  );
    return GHR_WIDTH'({hist, bit_in});
  endfunction

  logic [CNT_WIDTH-1:0]  cnt_q [ENTRY_NUM];
  logic [CNT_WIDTH-1:0]  cnt_cur_s;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [GHR_WIDTH-1:0]  ghr_q, ghr_d;
  logic [ADDR_WIDTH-1:0] ghr_ext_s;
  logic [ADDR_WIDTH-1:0] lkup_idx_s;
  logic                  pvalid_q, pvalid_d;
  logic                  ptaken_q, ptaken_d;
  logic [ADDR_WIDTH-1:0] pidx_q, pidx_d;
  logic [GHR_WIDTH-1:0]  pghr_q, pghr_d;
  logic [15:0]           mcnt_q, mcnt_d;
  logic                  recover_s;

  assign recover_s = predictor_wen & mispredict_ex;

  // Hashed lookup index: history sits in the index LSBs, upper bits zero.
  always_comb begin
    ghr_ext_s                  = {ADDR_WIDTH{1'b0}};
    ghr_ext_s[GHR_WIDTH-1:0]   = ghr_q;
    if (HASH_MODE != 0) begin
      lkup_idx_s = predictor_raddr ^ ghr_ext_s;
    end else begin
      lkup_idx_s = predictor_raddr;
    end
  end

  // Lookup result registers; the counter is read before any same-cycle update.
  always_comb begin
    pvalid_d = 1'b0;
    ptaken_d = ptaken_q;
    pidx_d   = pidx_q;
    pghr_d   = pghr_q;
    if (predictor_ren) begin
      pvalid_d = 1'b1;
      ptaken_d = cnt_q[lkup_idx_s][CNT_WIDTH-1];
      pidx_d   = lkup_idx_s;
      pghr_d   = ghr_q;
    end else begin
      pvalid_d = 1'b0;
    end
  end

  // Saturating counter next value for the entry being resolved.
  always_comb begin
    cnt_cur_s = cnt_q[predictor_waddr];
    cnt_d     = cnt_cur_s;
    if (branch_taken_ex) begin
      if (cnt_cur_s != CNT_MAX) begin
        cnt_d = cnt_cur_s + CNT_ONE;
      end else begin
        cnt_d = cnt_cur_s;
      end
    end else begin
      if (cnt_cur_s != CNT_MIN) begin
        cnt_d = cnt_cur_s - CNT_ONE;
      end else begin
        cnt_d = cnt_cur_s;
      end
    end
  end

  // History next value: mispredict repair overrides the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (recover_s) begin
      ghr_d = ghr_shift(ghr_restore, branch_taken_ex);
    end else if (pvalid_q) begin
      ghr_d = ghr_shift(ghr_q, ptaken_q);
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Mispredict counter next value, saturating at all-ones.
  always_comb begin
    mcnt_d = mcnt_q;
    if (recover_s && (mcnt_q != MCNT_MAX)) begin
      mcnt_d = mcnt_q + 16'd1;
    end else begin
      mcnt_d = mcnt_q;
    end
  end

  // Counter table storage with reset to the weakly-not-taken value.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        cnt_q[i] <= CNT_RST;
      end
    end else if (predictor_wen) begin
      cnt_q[predictor_waddr] <= cnt_d;
    end
  end

  // History, lookup result and mispredict counter registers.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      ghr_q    <= {GHR_WIDTH{1'b0}};
      pvalid_q <= 1'b0;
      ptaken_q <= 1'b0;
      pidx_q   <= {ADDR_WIDTH{1'b0}};
      pghr_q   <= {GHR_WIDTH{1'b0}};
      mcnt_q   <= 16'd0;
    end else begin
      ghr_q    <= ghr_d;
      pvalid_q <= pvalid_d;
      ptaken_q <= ptaken_d;
      pidx_q   <= pidx_d;
      pghr_q   <= pghr_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign predict_valid  = pvalid_q;
  assign predict_taken  = ptaken_q;
  assign predict_idx    = pidx_q;
  assign predict_ghr    = pghr_q;
  assign mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// -----------------------------------------------------------------------------
// tb_gshare_predictor
//   Self-checking bench for gshare_predictor with default parameters
//   (256 entries, 2-bit counters, 8-bit history, gshare hashing). Directed
//   scenarios use constant expectations; the random phase compares every
//   cycle against a behavioural model built from integer arithmetic.
// -----------------------------------------------------------------------------
module tb_gshare_predictor;

  logic        cpu_clk;
  logic        cpu_rstn;
  logic        predictor_ren;
  logic [7:0]  predictor_raddr;
  logic        predict_valid;
  logic        predict_taken;
  logic [7:0]  predict_idx;
  logic [7:0]  predict_ghr;
  logic        predictor_wen;
  logic [7:0]  predictor_waddr;
  logic        branch_taken_ex;
  logic        mispredict_ex;
  logic [7:0]  ghr_restore;
  logic [15:0] mispredict_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_cnt [256];
  int m_ghr;
  int m_pv, m_pt, m_pidx, m_pghr, m_mc;

  gshare_predictor dut (
    .cpu_clk         (cpu_clk),
    .cpu_rstn        (cpu_rstn),
    .predictor_ren   (predictor_ren),
    .predictor_raddr (predictor_raddr),
    .predict_valid   (predict_valid),
    .predict_taken   (predict_taken),
    .predict_idx     (predict_idx),
    .predict_ghr     (predict_ghr),
    .predictor_wen   (predictor_wen),
    .predictor_waddr (predictor_waddr),
    .branch_taken_ex (branch_taken_ex),
    .mispredict_ex   (mispredict_ex),
    .ghr_restore     (ghr_restore),
    .mispredict_cnt  (mispredict_cnt)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Model of one clock edge, evaluated from the inputs present at that edge.
  task automatic model_update();
    int idx, new_ghr, c;
    if (!cpu_rstn) begin
      for (int i = 0; i < 256; i++) m_cnt[i] = 1;
      m_ghr = 0; m_pv = 0; m_pt = 0; m_pidx = 0; m_pghr = 0; m_mc = 0;
    end else begin
      idx = int'(predictor_raddr) ^ m_ghr;
      new_ghr = m_ghr;
      if (m_pv != 0) new_ghr = (m_ghr * 2 + m_pt) % 256;
      if (predictor_wen && mispredict_ex) begin
        new_ghr = (int'(ghr_restore) * 2 + int'(branch_taken_ex)) % 256;
        if (m_mc < 65535) m_mc = m_mc + 1;
      end
      if (predictor_ren) begin
        m_pv = 1;
        m_pt = (m_cnt[idx] >= 2) ? 1 : 0;
        m_pidx = idx;
        m_pghr = m_ghr;
      end else begin
        m_pv = 0;
      end
      if (predictor_wen) begin
        c = m_cnt[predictor_waddr];
        if (branch_taken_ex) c = (c < 3) ? c + 1 : 3;
        else                 c = (c > 0) ? c - 1 : 0;
        m_cnt[predictor_waddr] = c;
      end
      m_ghr = new_ghr;
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rstn = 1'b1; predictor_ren = 1'b0; predictor_raddr = 8'h00;
    predictor_wen = 1'b0; predictor_waddr = 8'h00; branch_taken_ex = 1'b0;
    mispredict_ex = 1'b0; ghr_restore = 8'h00;
  endtask

  task automatic update(input logic [7:0] a, input logic t);
    idle_inputs();
    predictor_wen = 1'b1; predictor_waddr = a; branch_taken_ex = t;
    tick();
  endtask

  task automatic lookup(input logic [7:0] a);
    idle_inputs();
    predictor_ren = 1'b1; predictor_raddr = a;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    cpu_rstn = 1'b0; predictor_ren = 1'b1; predictor_wen = 1'b1;
    mispredict_ex = 1'b1; predictor_raddr = 8'h33;
    tick(); tick();
    n_checks++;
    if ({predict_valid, predict_taken, predict_idx, predict_ghr, mispredict_cnt} !== 34'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%0b t=%0b idx=%0h ghr=%0h mc=%0h expected all 0",
               predict_valid, predict_taken, predict_idx, predict_ghr, mispredict_cnt);
    end
    idle_inputs();
    tick();
    n_checks++;
    if (predict_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release_valid: got %0b expected 0", predict_valid);
    end
  endtask

  task automatic test_first_lookup();
    lookup(8'h05);
    n_checks++;
    if ({predict_valid, predict_taken, predict_idx, predict_ghr} !== {1'b1, 1'b0, 8'h05, 8'h00}) begin
      n_errors++;
      $display("FAIL first_lookup: got v=%0b t=%0b idx=%0h ghr=%0h expected 1 0 05 00",
               predict_valid, predict_taken, predict_idx, predict_ghr);
    end
    lookup(8'h07);
    n_checks++;
    if ({predict_idx, predict_ghr} !== {8'h07, 8'h00}) begin
      n_errors++;
      $display("FAIL ghr_after_shift0: got idx=%0h ghr=%0h expected 07 00", predict_idx, predict_ghr);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_saturation();
    logic [7:0] g;
    logic exp_t [7];
    logic tk [7];
    tk = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      update(8'h10, tk[i]);
      g = 8'(m_ghr);
      lookup(8'h10 ^ g);
      n_checks++;
      if (predict_taken !== exp_t[i] || predict_idx !== 8'h10) begin
        n_errors++;
        $display("FAIL saturation_step%0d: got t=%0b idx=%0h expected t=%0b idx=10",
                 i, predict_taken, predict_idx, exp_t[i]);
      end
      idle_inputs(); tick();
    end
  endtask

  task automatic test_gshare_hash();
    idle_inputs();
    predictor_wen = 1'b1; mispredict_ex = 1'b1; branch_taken_ex = 1'b1;
    ghr_restore = 8'h52; predictor_waddr = 8'h99;
    tick();
    lookup(8'hF0);
    n_checks++;
    if ({predict_valid, predict_idx, predict_ghr} !== {1'b1, 8'h55, 8'hA5}) begin
      n_errors++;
      $display("FAIL gshare_hash: got v=%0b idx=%0h ghr=%0h expected 1 55 a5",
               predict_valid, predict_idx, predict_ghr);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_priority();
    logic [15:0] mc_before;
    logic [7:0]  g;
    update(8'h40, 1'b1);
    update(8'h40, 1'b1);
    g = 8'(m_ghr);
    lookup(8'h40 ^ g);
    n_checks++;
    if (predict_valid !== 1'b1 || predict_taken !== 1'b1) begin
      n_errors++;
      $display("FAIL priority_setup: got v=%0b t=%0b expected 1 1", predict_valid, predict_taken);
    end
    mc_before = mispredict_cnt;
    idle_inputs();
    predictor_wen = 1'b1; mispredict_ex = 1'b1; branch_taken_ex = 1'b0;
    ghr_restore = 8'h0F; predictor_waddr = 8'h41;
    tick();
    n_checks++;
    if (mispredict_cnt !== mc_before + 16'd1) begin
      n_errors++;
      $display("FAIL priority_mcnt: got %0h expected %0h", mispredict_cnt, mc_before + 16'd1);
    end
    lookup(8'h00);
    n_checks++;
    if (predict_ghr !== 8'h1E) begin
      n_errors++;
      $display("FAIL priority_ghr: got %0h expected 1e", predict_ghr);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_same_index();
    idle_inputs();
    predictor_wen = 1'b1; mispredict_ex = 1'b1; branch_taken_ex = 1'b0;
    ghr_restore = 8'h00; predictor_waddr = 8'h77;
    tick();
    idle_inputs();
    predictor_ren = 1'b1; predictor_raddr = 8'h20;
    predictor_wen = 1'b1; predictor_waddr = 8'h20; branch_taken_ex = 1'b1;
    tick();
    n_checks++;
    if ({predict_valid, predict_taken, predict_idx} !== {1'b1, 1'b0, 8'h20}) begin
      n_errors++;
      $display("FAIL rdw_old_value: got v=%0b t=%0b idx=%0h expected 1 0 20",
               predict_valid, predict_taken, predict_idx);
    end
    lookup(8'h20);
    n_checks++;
    if (predict_taken !== 1'b1 || predict_idx !== 8'h20) begin
      n_errors++;
      $display("FAIL rdw_update_kept: got t=%0b idx=%0h expected 1 20", predict_taken, predict_idx);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cpu_rstn        = ($urandom_range(0, 79) != 0);
      predictor_ren   = 1'($urandom_range(0, 3) != 0);
      predictor_raddr = 8'($urandom);
      predictor_wen   = 1'($urandom_range(0, 1));
      predictor_waddr = 8'($urandom_range(0, 15));
      branch_taken_ex = 1'($urandom_range(0, 1));
      mispredict_ex   = 1'($urandom_range(0, 3) == 0);
      ghr_restore     = 8'($urandom);
      tick();
      n_checks++;
      if (predict_valid !== 1'(m_pv) || predict_taken !== 1'(m_pt) ||
          predict_idx !== 8'(m_pidx) || predict_ghr !== 8'(m_pghr) ||
          mispredict_cnt !== 16'(m_mc)) begin
        n_errors++;
        $display("FAIL random_cycle%0d: got v=%0b t=%0b idx=%0h ghr=%0h mc=%0h expected v=%0b t=%0b idx=%0h ghr=%0h mc=%0h",
                 i, predict_valid, predict_taken, predict_idx, predict_ghr, mispredict_cnt,
                 m_pv, m_pt, m_pidx, m_pghr, m_mc);
      end
    end
    idle_inputs(); tick();
  endtask

  task automatic test_midrun_reset();
    logic [7:0] addrs [3];
    addrs = '{8'h00, 8'h05, 8'hFF};
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      predictor_ren = 1'b1; predictor_raddr = 8'($urandom);
      predictor_wen = 1'b1; predictor_waddr = 8'($urandom_range(0, 7));
      branch_taken_ex = 1'b1; mispredict_ex = 1'($urandom_range(0, 1));
      ghr_restore = 8'($urandom);
      tick();
    end
    cpu_rstn = 1'b0;
    tick();
    n_checks++;
    if ({predict_valid, predict_taken, predict_idx, predict_ghr, mispredict_cnt} !== 34'd0) begin
      n_errors++;
      $display("FAIL midrun_reset: got v=%0b t=%0b idx=%0h ghr=%0h mc=%0h expected all 0",
               predict_valid, predict_taken, predict_idx, predict_ghr, mispredict_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      lookup(addrs[i]);
      n_checks++;
      if ({predict_valid, predict_taken, predict_idx, predict_ghr} !== {1'b1, 1'b0, addrs[i], 8'h00}) begin
        n_errors++;
        $display("FAIL post_reset_lookup%0d: got v=%0b t=%0b idx=%0h ghr=%0h expected 1 0 %0h 00",
                 i, predict_valid, predict_taken, predict_idx, predict_ghr, addrs[i]);
      end
    end
    idle_inputs(); tick();
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 256; i++) m_cnt[i] = 1;
    m_ghr = 0; m_pv = 0; m_pt = 0; m_pidx = 0; m_pghr = 0; m_mc = 0;
    test_reset();
    test_first_lookup();
    test_saturation();
    test_gshare_hash();
    test_priority();
    test_same_index();
    test_random();
    test_midrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
